core_ctrl_seq: RTL and testbench
================================

Name: core_ctrl_seq

Overview:
- Sequencer that drives the memory controller's 3-bit data-condition command bus through a complete job: store operands, then a programmable number of transfer/process rounds, then return to idle.
- Handshakes with the processing-unit array (start pulse / done level).
- Guards every wait state with a watchdog; on expiry it walks the memory controller back to idle with a fixed abort sequence.
- Sits between the host/top-level control and the memory controller plus processing units.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in any wait state before abort (8-bit watchdog)
MEM_DEPTH, 32, largest legal operand count; lengths above it are clamped

Ports:
cc_clk  in  1  clock, rising edge
cc_reset  in  1  asynchronous, active-low reset
cc_start  in  1  job request, sampled in IDLE only
cc_length  in  6  operand-pair count for the job
cc_rounds  in  4  number of transfer/process rounds
mc_done  in  1  memory controller phase-complete flag
cc_pu_done  in  1  processing units finished current round (level)
cc_data_contition  out  3  command to memory controller: 000 idle, 100 store, 010 halt/next, 001 process
cc_data_length  out  6  latched length forwarded to memory controller
cc_pu_start  out  1  one-cycle pulse, start processing round
cc_busy  out  1  high from job accept until return to IDLE
cc_job_done  out  1  one-cycle pulse on normal completion
cc_error  out  1  sticky; set by bad request or watchdog abort, cleared on next accepted start
cc_round_cnt  out  4  rounds completed in current job

Behaviour:
- All outputs registered. On cc_reset=0 (async): state IDLE, cc_data_contition=000, cc_data_length=0, cc_pu_start=0, cc_busy=0, cc_job_done=0, cc_error=0, cc_round_cnt=0, watchdog=0.
- Reset mid-job aborts immediately; no abort sequence is emitted.
- Watchdog: cleared on every state entry; increments each cycle in STORE, XFER and PROC. When it equals TIMEOUT_CYCLES, go to ABORT1.
- IDLE: drive 000.
  - On cc_start=1 with cc_length=0 or cc_rounds=0: set cc_error, stay in IDLE.
  - On cc_start=1 otherwise: latch cc_data_length = min(cc_length, MEM_DEPTH-1), latch rounds, clear cc_error and cc_round_cnt, set cc_busy, go to STORE.
  - Latency: start sampled at edge N; 100 appears after edge N+1.
- STORE: drive 100; wait for mc_done=1, then go to XFER.
- XFER: drive 010; ignore mc_done in the first cycle after entry (stale flag); from the second cycle, on mc_done=1 go to PROC.
- PROC: drive 001.
  - cc_pu_start pulses exactly once, in the first cycle of PROC.
  - On cc_pu_done=1 (earliest the cycle after the pulse), increment cc_round_cnt.
  - If the new count equals the latched rounds, go to FINISH; otherwise go to XFER.
- FINISH: drive 000 for one cycle, pulse cc_job_done, clear cc_busy on exit, go to IDLE.
- ABORT1 -> ABORT2 -> ABORT3, one cycle each, driving 010, 001, 000 respectively. Set cc_error on entry to ABORT1. Return to IDLE with cc_busy cleared and no cc_job_done pulse.
- cc_start outside IDLE is ignored.
- cc_pu_done high before the pulse, or held across rounds, does not count until the cycle after the pulse.
- Simultaneous watchdog expiry and completion event in the same cycle: the completion event wins.
- cc_round_cnt is 4-bit and never wraps, because rounds ≤ 15 is enforced by the port width.

Test Plan:
- Reset released, cc_start=1, cc_length=10, cc_rounds=2, mc_done after 5 cycles in each STORE/XFER, cc_pu_done 3 cycles after each pulse -> command sequence 100,010,001,010,001,000; two cc_pu_start pulses; cc_round_cnt=2; one cc_job_done; cc_data_length=10.
- cc_start with cc_length=0 -> cc_error=1, cc_busy=0, command stays 000. A following valid start clears cc_error.
- cc_length=63 -> cc_data_length=31.
- mc_done held low in STORE -> after 255 cycles commands 010,001,000, cc_error=1, no cc_job_done, IDLE.
- cc_pu_done held high throughout, rounds=3 -> exactly 3 pulses, one round counted per PROC entry, job completes.
- Assert cc_reset during PROC in round 1 -> all outputs zero asynchronously; a new job then runs normally from STORE.

Source files
------------

// File: rtl/core_ctrl_seq.sv
// Job sequencer: drives the memory controller command bus through store, N transfer/process
// rounds and back to idle, handshaking with the processing units under a per-state watchdog.
module core_ctrl_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MEM_DEPTH      = 32
) (
  input  logic       cc_clk,
  input  logic       cc_reset,
  input  logic       cc_start,
  input  logic [5:0] cc_length,
  input  logic [3:0] cc_rounds,
  input  logic       mc_done,
  input  logic       cc_pu_done,
  output logic [2:0] cc_data_contition,
  output logic [5:0] cc_data_length,
  output logic       cc_pu_start,
  output logic       cc_busy,
  output logic       cc_job_done,
  output logic       cc_error,
  output logic [3:0] cc_round_cnt
);

  localparam logic [7:0] Timeout  = 8'(TIMEOUT_CYCLES);
  localparam logic [5:0] MaxLen   = 6'(MEM_DEPTH - 1);
  localparam logic [2:0] CmdIdle  = 3'b000;
  localparam logic [2:0] CmdStore = 3'b100;
  localparam logic [2:0] CmdNext  = 3'b010;
  localparam logic [2:0] CmdProc  = 3'b001;

  typedef enum logic [2:0] {
    StIdle, StStore, StXfer, StProc, StFinish, StAbort1, StAbort2, StAbort3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wdog_q, wdog_d;
  logic [3:0] rounds_q, rounds_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic [3:0] round_inc;
  logic [5:0] len_q, len_d;
  logic [2:0] cmd_q, cmd_d;
  logic       pu_start_q, pu_start_d;
  logic       busy_q, busy_d;
  logic       job_done_q, job_done_d;
  logic       error_q, error_d;
  logic       expired;
  logic       first_cycle;

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    rounds_d    = rounds_q;
    round_cnt_d = round_cnt_q;
    len_d       = len_q;
    pu_start_d  = 1'b0;
    busy_d      = busy_q;
    job_done_d  = 1'b0;
    error_d     = error_q;
    round_inc   = round_cnt_q + 4'd1;
    expired     = (wdog_q == Timeout);
    // The watchdog is zero only in the first cycle after entering a state.
    first_cycle = (wdog_q == 8'd0);
    cmd_d       = CmdIdle;

    // The command bus reflects the state held during the previous cycle.
    unique case (state_q)
      StStore:  cmd_d = CmdStore;
      StXfer:   cmd_d = CmdNext;
      StProc:   cmd_d = CmdProc;
      StAbort1: cmd_d = CmdNext;
      StAbort2: cmd_d = CmdProc;
      default:  cmd_d = CmdIdle;
    endcase

    unique case (state_q)
      StIdle: begin
        if (cc_start) begin
          if (cc_length == 6'd0 || cc_rounds == 4'd0) begin
            error_d = 1'b1;
          end else begin
            len_d       = (cc_length > MaxLen) ? MaxLen : cc_length;
            rounds_d    = cc_rounds;
            error_d     = 1'b0;
            round_cnt_d = 4'd0;
            busy_d      = 1'b1;
            state_d     = StStore;
          end
        end
      end
      StStore: begin
        if (mc_done) begin
          state_d = StXfer;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = StAbort1;
        end
      end
      StXfer: begin
        if (mc_done && !first_cycle) begin
          pu_start_d = 1'b1;
          state_d    = StProc;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = StAbort1;
        end
      end
      StProc: begin
        if (cc_pu_done && !first_cycle) begin
          round_cnt_d = round_inc;
          if (round_inc == rounds_q) begin
            job_done_d = 1'b1;
            state_d    = StFinish;
          end else begin
            state_d = StXfer;
          end
        end else if (expired) begin
          error_d = 1'b1;
          state_d = StAbort1;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StAbort1: state_d = StAbort2;
      StAbort2: state_d = StAbort3;
      StAbort3: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      wdog_d = 8'd0;
    end else if (state_q == StStore || state_q == StXfer || state_q == StProc) begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  always_ff @(posedge cc_clk or negedge cc_reset) begin
    if (!cc_reset) begin
      state_q     <= StIdle;
      wdog_q      <= 8'd0;
      rounds_q    <= 4'd0;
      round_cnt_q <= 4'd0;
      len_q       <= 6'd0;
      cmd_q       <= CmdIdle;
      pu_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      rounds_q    <= rounds_d;
      round_cnt_q <= round_cnt_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      pu_start_q  <= pu_start_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
      error_q     <= error_d;
    end
  end

  assign cc_data_contition = cmd_q;
  assign cc_data_length    = len_q;
  assign cc_pu_start       = pu_start_q;
  assign cc_busy           = busy_q;
  assign cc_job_done       = job_done_q;
  assign cc_error          = error_q;
  assign cc_round_cnt      = round_cnt_q;

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Bench for core_ctrl_seq: request table, directed corner jobs and randomized jobs checked
// against a transaction-level model of the expected command sequence and handshakes.
module tb_core_ctrl_seq;

  logic       cc_clk = 1'b0;
  logic       cc_reset;
  logic       cc_start;
  logic [5:0] cc_length;
  logic [3:0] cc_rounds;
  logic       mc_done;
  logic       cc_pu_done;
  logic [2:0] cc_data_contition;
  logic [5:0] cc_data_length;
  logic       cc_pu_start;
  logic       cc_busy;
  logic       cc_job_done;
  logic       cc_error;
  logic [3:0] cc_round_cnt;

  int errors = 0;
  int checks = 0;

  core_ctrl_seq dut (
    .cc_clk            (cc_clk),
    .cc_reset          (cc_reset),
    .cc_start          (cc_start),
    .cc_length         (cc_length),
    .cc_rounds         (cc_rounds),
    .mc_done           (mc_done),
    .cc_pu_done        (cc_pu_done),
    .cc_data_contition (cc_data_contition),
    .cc_data_length    (cc_data_length),
    .cc_pu_start       (cc_pu_start),
    .cc_busy           (cc_busy),
    .cc_job_done       (cc_job_done),
    .cc_error          (cc_error),
    .cc_round_cnt      (cc_round_cnt)
  );

  always #5 cc_clk = ~cc_clk;

  typedef struct {
    bit start;
    int len;
    int rounds;
    int err;
    int busy;
    int dlen;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cmd"}, int'(cc_data_contition), 0);
    check({name, "_dlen"}, int'(cc_data_length), 0);
    check({name, "_pu_start"}, int'(cc_pu_start), 0);
    check({name, "_busy"}, int'(cc_busy), 0);
    check({name, "_job_done"}, int'(cc_job_done), 0);
    check({name, "_error"}, int'(cc_error), 0);
    check({name, "_round_cnt"}, int'(cc_round_cnt), 0);
  endtask

  // dmc == 0 means the memory controller never answers, so the job must abort from STORE.
  // rst_at > 0 asserts reset right after the rst_at-th processing-start pulse.
  task automatic run_job(input string name, input int len, input int rounds, input int dmc,
                         input int dpu, input bit pu_hold, input bit noise, input int rst_at);
    int  got_q[$];
    int  exp_q[$];
    int  prev_cmd, mc_cnt, pu_cnt, pulses, dones, store_cyc, rise_cyc, first_store, n;
    bit  seen_busy, finished, abort;
    abort       = (dmc == 0);
    prev_cmd    = 0;
    mc_cnt      = 0;
    pu_cnt      = 0;
    pulses      = 0;
    dones       = 0;
    store_cyc   = 0;
    rise_cyc    = -1;
    first_store = -1;
    seen_busy   = 1'b0;
    finished    = 1'b0;

    @(negedge cc_clk);
    cc_start   = 1'b1;
    cc_length  = 6'(len);
    cc_rounds  = 4'(rounds);
    mc_done    = 1'b0;
    cc_pu_done = pu_hold;

    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      @(negedge cc_clk);
      if (cc_busy && !seen_busy) begin
        seen_busy = 1'b1;
        rise_cyc  = cyc;
      end
      if (int'(cc_data_contition) != prev_cmd) begin
        prev_cmd = int'(cc_data_contition);
        got_q.push_back(prev_cmd);
        if (prev_cmd == 4 && first_store < 0) first_store = cyc;
        if ((prev_cmd == 4 || prev_cmd == 2) && dmc > 0) mc_cnt = dmc;
      end
      if (cc_data_contition == 3'b100) store_cyc++;
      if (cc_pu_start) begin
        pulses++;
        pu_cnt = dpu;
      end
      if (cc_job_done) dones++;

      if (rst_at > 0 && pulses == rst_at) begin
        #2 cc_reset = 1'b0;
        #1;
        check_all_zero({name, "_async_rst"});
        cc_start   = 1'b0;
        mc_done    = 1'b0;
        cc_pu_done = 1'b0;
        #1 cc_reset = 1'b1;
        return;
      end

      mc_done = 1'b0;
      if (mc_cnt > 0) begin
        mc_cnt--;
        if (mc_cnt == 0) mc_done = 1'b1;
      end
      if (!pu_hold) begin
        cc_pu_done = 1'b0;
        if (pu_cnt > 0) begin
          pu_cnt--;
          if (pu_cnt == 0) cc_pu_done = 1'b1;
        end
      end
      // Requests while busy must be ignored; never leave start high once back in IDLE.
      if (cc_busy && noise) begin
        cc_start  = 1'($urandom_range(0, 1));
        cc_length = 6'($urandom_range(0, 63));
        cc_rounds = 4'($urandom_range(0, 15));
      end else begin
        cc_start  = 1'b0;
        cc_length = 6'(len);
        cc_rounds = 4'(rounds);
      end
      if (seen_busy && !cc_busy) finished = 1'b1;
    end
    cc_start   = 1'b0;
    mc_done    = 1'b0;
    cc_pu_done = 1'b0;

    // Reference: store, then (next, process) per round, then idle; abort walks next/process/idle.
    exp_q.push_back(4);
    if (abort) begin
      exp_q.push_back(2);
      exp_q.push_back(1);
    end else begin
      for (int r = 0; r < rounds; r++) begin
        exp_q.push_back(2);
        exp_q.push_back(1);
      end
    end
    exp_q.push_back(0);

    check({name, "_terminates"}, int'(finished), 1);
    check({name, "_store_latency"}, first_store - rise_cyc, 1);
    check({name, "_cmd_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_cmd[%0d]", name, i), got_q[i], exp_q[i]);
    end
    check({name, "_pu_pulses"}, pulses, abort ? 0 : rounds);
    check({name, "_job_done"}, dones, abort ? 0 : 1);
    check({name, "_round_cnt"}, int'(cc_round_cnt), abort ? 0 : rounds);
    check({name, "_error"}, int'(cc_error), int'(abort));
    check({name, "_dlen"}, int'(cc_data_length), (len > 31) ? 31 : len);
    if (abort) check({name, "_store_wait_in_window"}, int'(store_cyc >= 255 && store_cyc <= 257), 1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 0, 5, 1, 0, 0};
    vecs[1] = '{1'b0, 10, 2, 1, 0, 0};
    vecs[2] = '{1'b1, 7, 0, 1, 0, 0};
    vecs[3] = '{1'b1, 10, 2, 0, 1, 10};
    vecs[4] = '{1'b1, 0, 0, 1, 0, 0};
    vecs[5] = '{1'b1, 63, 1, 0, 1, 31};
    vecs[6] = '{1'b1, 32, 4, 0, 1, 31};
    vecs[7] = '{1'b1, 31, 15, 0, 1, 31};
    vecs[8] = '{1'b1, 1, 1, 0, 1, 1};
    vecs[9] = '{1'b0, 0, 0, 0, 0, 0};

    cc_reset   = 1'b0;
    cc_start   = 1'b0;
    cc_length  = 6'd0;
    cc_rounds  = 4'd0;
    mc_done    = 1'b0;
    cc_pu_done = 1'b0;
    repeat (2) @(negedge cc_clk);
    check_all_zero("reset");
    cc_reset = 1'b1;

    // Single requests in IDLE; accepted ones are cleared with a reset before the next row.
    for (int i = 0; i < 10; i++) begin
      @(negedge cc_clk);
      cc_start  = vecs[i].start;
      cc_length = 6'(vecs[i].len);
      cc_rounds = 4'(vecs[i].rounds);
      @(negedge cc_clk);
      cc_start = 1'b0;
      check($sformatf("vec%0d_error", i), int'(cc_error), vecs[i].err);
      check($sformatf("vec%0d_busy", i), int'(cc_busy), vecs[i].busy);
      check($sformatf("vec%0d_dlen", i), int'(cc_data_length), vecs[i].dlen);
      check($sformatf("vec%0d_cmd", i), int'(cc_data_contition), 0);
      if (vecs[i].busy != 0) begin
        cc_reset = 1'b0;
        #1 cc_reset = 1'b1;
      end
    end

    run_job("spec_job", 10, 2, 5, 3, 1'b0, 1'b0, 0);
    run_job("store_timeout", 12, 3, 0, 0, 1'b0, 1'b0, 0);
    run_job("after_abort", 4, 1, 3, 2, 1'b0, 1'b0, 0);
    run_job("pu_done_held", 8, 3, 4, 0, 1'b1, 1'b0, 0);
    run_job("rst_in_proc", 20, 3, 2, 3, 1'b0, 1'b0, 1);
    run_job("post_reset", 63, 2, 3, 2, 1'b0, 1'b0, 0);

    for (int j = 0; j < 15; j++) begin
      run_job($sformatf("rand%0d", j), $urandom_range(1, 63), $urandom_range(1, 15),
              $urandom_range(1, 20), $urandom_range(2, 20), 1'b0, 1'b1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
